// File: rtl/sam_kbd_pkg.sv
// Shared types, PS/2 prefix bytes and scan-code lookup for the SAM keyboard interface.
// Used with or without the SAMKBD_PARITY_CHECK_EN build option.
package sam_kbd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } rx_state_t;

  typedef struct packed {
    logic       valid;
    logic [3:0] row;
    logic [2:0] col;
  } key_pos_t;

  localparam logic [7:0] KC_EXT  = 8'hE0;
  localparam logic [7:0] KC_BRK  = 8'hF0;
  localparam logic [7:0] KC_OVR0 = 8'h00;
  localparam logic [7:0] KC_OVR1 = 8'hFF;

  function automatic key_pos_t kp(input logic [3:0] row, input logic [2:0] col);
    return {1'b1, row, col};
  endfunction

  // Set-2 scan code to SAM matrix position; rows 0..7 follow addr[8..15], row 8 holds cursor keys.
  function automatic key_pos_t key_map(input logic ext, input logic [7:0] code);
    key_pos_t p;
    p = {1'b0, 4'd0, 3'd0};
    if (ext) begin
      case (code)
        8'h75:   p = kp(4'd8, 3'd1);
        8'h72:   p = kp(4'd8, 3'd2);
        8'h6B:   p = kp(4'd8, 3'd3);
        8'h74:   p = kp(4'd8, 3'd4);
        default: p = {1'b0, 4'd0, 3'd0};
      endcase
    end else begin
      case (code)
        8'h1A: p = kp(4'd0, 3'd1);  8'h22: p = kp(4'd0, 3'd2);
        8'h21: p = kp(4'd0, 3'd3);  8'h2A: p = kp(4'd0, 3'd4);
        8'h1C: p = kp(4'd1, 3'd0);  8'h1B: p = kp(4'd1, 3'd1);
        8'h23: p = kp(4'd1, 3'd2);  8'h2B: p = kp(4'd1, 3'd3);
        8'h34: p = kp(4'd1, 3'd4);
        8'h15: p = kp(4'd2, 3'd0);  8'h1D: p = kp(4'd2, 3'd1);
        8'h24: p = kp(4'd2, 3'd2);  8'h2D: p = kp(4'd2, 3'd3);
        8'h2C: p = kp(4'd2, 3'd4);
        8'h16: p = kp(4'd3, 3'd0);  8'h1E: p = kp(4'd3, 3'd1);
        8'h26: p = kp(4'd3, 3'd2);  8'h25: p = kp(4'd3, 3'd3);
        8'h2E: p = kp(4'd3, 3'd4);  8'h76: p = kp(4'd3, 3'd5);
        8'h0D: p = kp(4'd3, 3'd6);  8'h58: p = kp(4'd3, 3'd7);
        8'h45: p = kp(4'd4, 3'd0);  8'h46: p = kp(4'd4, 3'd1);
        8'h3E: p = kp(4'd4, 3'd2);  8'h3D: p = kp(4'd4, 3'd3);
        8'h36: p = kp(4'd4, 3'd4);  8'h4E: p = kp(4'd4, 3'd5);
        8'h55: p = kp(4'd4, 3'd6);  8'h66: p = kp(4'd4, 3'd7);
        8'h4D: p = kp(4'd5, 3'd0);  8'h44: p = kp(4'd5, 3'd1);
        8'h43: p = kp(4'd5, 3'd2);  8'h3C: p = kp(4'd5, 3'd3);
        8'h35: p = kp(4'd5, 3'd4);
        8'h5A: p = kp(4'd6, 3'd0);  8'h4B: p = kp(4'd6, 3'd1);
        8'h42: p = kp(4'd6, 3'd2);  8'h3B: p = kp(4'd6, 3'd3);
        8'h33: p = kp(4'd6, 3'd4);
        8'h29: p = kp(4'd7, 3'd0);  8'h3A: p = kp(4'd7, 3'd2);
        8'h31: p = kp(4'd7, 3'd3);  8'h32: p = kp(4'd7, 3'd4);
        8'h41: p = kp(4'd7, 3'd5);  8'h49: p = kp(4'd7, 3'd6);
        default: p = {1'b0, 4'd0, 3'd0};
      endcase
    end
    return p;
  endfunction

  function automatic logic [11:1] fn_mask(input logic ext, input logic [7:0] code);
    logic [11:1] m;
    case (code)
      8'h05:   m = 11'h001;
      8'h06:   m = 11'h002;
      8'h04:   m = 11'h004;
      8'h0C:   m = 11'h008;
      8'h03:   m = 11'h010;
      8'h0B:   m = 11'h020;
      8'h83:   m = 11'h040;
      8'h0A:   m = 11'h080;
      8'h01:   m = 11'h100;
      8'h09:   m = 11'h200;
      8'h78:   m = 11'h400;
      default: m = 11'h000;
    endcase
    return ext ? 11'h000 : m;
  endfunction

  // Returns {right[2:0], left[2:0]} with bit order shift, alt, ctrl; E0 12 is a fake shift and is ignored.
  function automatic logic [5:0] mod_mask(input logic ext, input logic [7:0] code);
    logic [5:0] m;
    case (code)
      8'h12:   m = ext ? 6'b000_000 : 6'b000_001;
      8'h59:   m = ext ? 6'b000_000 : 6'b001_000;
      8'h11:   m = ext ? 6'b010_000 : 6'b000_010;
      8'h14:   m = ext ? 6'b100_000 : 6'b000_100;
      default: m = 6'b000_000;
    endcase
    return m;
  endfunction

  function automatic logic parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_rx.sv
// PS/2 frame receiver: synchronises the PS/2 lines, samples on falling clock edges and
// drops partial frames after an idle timeout. Emits the byte with a one-cycle valid strobe.
module ps2_rx
  import sam_kbd_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 96000000,
  parameter int unsigned TIMEOUT_US = 1000
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] rx_byte,
  output logic       rx_parity,
  output logic       rx_valid
);

  localparam int unsigned TMO_CYCLES = (CLK_HZ / 32'd1000000) * TIMEOUT_US;
  localparam int unsigned TMO_W      = $clog2(TMO_CYCLES + 32'd1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CYCLES - 32'd1);

  logic [2:0]       clk_sync_q, clk_sync_d;
  logic [1:0]       dat_sync_q, dat_sync_d;
  rx_state_t        state_q, state_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       shift_q, shift_d;
  logic             parity_q, parity_d;
  logic             valid_q, valid_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             fall_s, bit_s, timeout_s;

  assign fall_s    = clk_sync_q[2] & ~clk_sync_q[1];
  assign bit_s     = dat_sync_q[1];
  // An edge landing on the expiry cycle loses to the timeout.
  assign timeout_s = (state_q != ST_IDLE) && (tmo_q == TMO_LAST);

  // Next-state logic for synchronisers, frame FSM and idle timer.
  always_comb begin
    clk_sync_d = {clk_sync_q[1:0], ps2_clk};
    dat_sync_d = {dat_sync_q[0], ps2_data};
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    parity_d   = parity_q;
    valid_d    = 1'b0;
    tmo_d      = tmo_q;
    if (timeout_s) begin
      state_d   = ST_IDLE;
      bit_cnt_d = 3'd0;
      tmo_d     = {TMO_W{1'b0}};
    end else if (fall_s) begin
      tmo_d = {TMO_W{1'b0}};
      case (state_q)
        ST_IDLE: begin
          bit_cnt_d = 3'd0;
          state_d   = bit_s ? ST_IDLE : ST_DATA;
        end
        ST_DATA: begin
          shift_d   = {bit_s, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          state_d   = (bit_cnt_q == 3'd7) ? ST_PARITY : ST_DATA;
        end
        ST_PARITY: begin
          parity_d = bit_s;
          state_d  = ST_STOP;
        end
        ST_STOP: begin
          valid_d = bit_s;
          state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end else if (state_q != ST_IDLE) begin
      tmo_d = tmo_q + TMO_W'(1);
    end else begin
      tmo_d = {TMO_W{1'b0}};
    end
  end

  // State registers; lines reset to their idle-high level so release cannot fake an edge.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      clk_sync_q <= 3'b111;
      dat_sync_q <= 2'b11;
      state_q    <= ST_IDLE;
      bit_cnt_q  <= 3'd0;
      shift_q    <= 8'h00;
      parity_q   <= 1'b0;
      valid_q    <= 1'b0;
      tmo_q      <= {TMO_W{1'b0}};
    end else begin
      clk_sync_q <= clk_sync_d;
      dat_sync_q <= dat_sync_d;
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      parity_q   <= parity_d;
      valid_q    <= valid_d;
      tmo_q      <= tmo_d;
    end
  end

  assign rx_byte   = shift_q;
  assign rx_parity = parity_q;
  assign rx_valid  = valid_q;

endmodule

// File: rtl/sam_keyboard.sv
// SAM Coupe keyboard from a PS/2 keyboard: scan-code decoder, 9x8 key matrix, Fn and modifier flags.
// Build option SAMKBD_PARITY_CHECK_EN discards bytes received with bad (even) parity.
module sam_keyboard
  import sam_kbd_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 96000000,
  parameter int unsigned TIMEOUT_US = 1000
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ps2_kbd_clk,
  input  logic        ps2_kbd_data,
  input  logic [15:0] addr,
  output logic [7:0]  key_data,
  output logic [11:1] Fn,
  output logic [2:0]  mod
);

  logic [7:0]      rx_byte;
  logic            rx_parity, rx_valid;
  logic            byte_ok_s, par_fail_s, overrun_s, unused_s;
  logic            ext_q, ext_d, brk_q, brk_d;
  logic [8:0][7:0] matrix_q, matrix_d, key_hit_s;
  logic [11:1]     fn_q, fn_d, fn_hit_s;
  logic [2:0]      mod_l_q, mod_l_d, mod_r_q, mod_r_d, mod_q, mod_d;
  logic [5:0]      mod_hit_s;
  key_pos_t        key_pos_s;
  logic [7:0]      held_s;

  ps2_rx #(
    .CLK_HZ    (CLK_HZ),
    .TIMEOUT_US(TIMEOUT_US)
  ) u_rx (
    .clk_sys  (clk_sys),
    .reset    (reset),
    .ps2_clk  (ps2_kbd_clk),
    .ps2_data (ps2_kbd_data),
    .rx_byte  (rx_byte),
    .rx_parity(rx_parity),
    .rx_valid (rx_valid)
  );

`ifdef SAMKBD_PARITY_CHECK_EN
  assign byte_ok_s  = rx_valid & parity_ok(rx_byte, rx_parity);
  assign par_fail_s = rx_valid & ~parity_ok(rx_byte, rx_parity);
  assign unused_s   = ^addr[7:0];
`else
  assign byte_ok_s  = rx_valid;
  assign par_fail_s = 1'b0;
  assign unused_s   = ^{addr[7:0], rx_parity};
`endif

  assign overrun_s = byte_ok_s && ((rx_byte == KC_OVR0) || (rx_byte == KC_OVR1));
  assign key_pos_s = key_map(ext_q, rx_byte);
  assign fn_hit_s  = fn_mask(ext_q, rx_byte);
  assign mod_hit_s = mod_mask(ext_q, rx_byte);

  // One-hot matrix mask for the decoded key.
  always_comb begin
    for (int r = 0; r < 9; r++) begin
      key_hit_s[r] = (key_pos_s.valid && (key_pos_s.row == 4'(r))) ? (8'd1 << key_pos_s.col) : 8'd0;
    end
  end

  // Decoder: prefix flags, make/break application and overrun release.
  always_comb begin
    ext_d    = ext_q;
    brk_d    = brk_q;
    matrix_d = matrix_q;
    fn_d     = fn_q;
    mod_l_d  = mod_l_q;
    mod_r_d  = mod_r_q;
    if (overrun_s) begin
      ext_d    = 1'b0;
      brk_d    = 1'b0;
      matrix_d = {72{1'b0}};
      fn_d     = 11'h000;
      mod_l_d  = 3'b000;
      mod_r_d  = 3'b000;
    end else if (par_fail_s) begin
      ext_d = 1'b0;
      brk_d = 1'b0;
    end else if (byte_ok_s && (rx_byte == KC_EXT)) begin
      ext_d = 1'b1;
    end else if (byte_ok_s && (rx_byte == KC_BRK)) begin
      brk_d = 1'b1;
    end else if (byte_ok_s) begin
      ext_d = 1'b0;
      brk_d = 1'b0;
      if (brk_q) begin
        matrix_d           = matrix_q & ~key_hit_s;
        fn_d               = fn_q & ~fn_hit_s;
        {mod_r_d, mod_l_d} = {mod_r_q, mod_l_q} & ~mod_hit_s;
      end else begin
        matrix_d           = matrix_q | key_hit_s;
        fn_d               = fn_q | fn_hit_s;
        {mod_r_d, mod_l_d} = {mod_r_q, mod_l_q} | mod_hit_s;
      end
    end else begin
      ext_d = ext_q;
      brk_d = brk_q;
    end
    mod_d = mod_l_d | mod_r_d;
  end

  // Decoder and matrix state.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      ext_q    <= 1'b0;
      brk_q    <= 1'b0;
      matrix_q <= {72{1'b0}};
      fn_q     <= 11'h000;
      mod_l_q  <= 3'b000;
      mod_r_q  <= 3'b000;
      mod_q    <= 3'b000;
    end else begin
      ext_q    <= ext_d;
      brk_q    <= brk_d;
      matrix_q <= matrix_d;
      fn_q     <= fn_d;
      mod_l_q  <= mod_l_d;
      mod_r_q  <= mod_r_d;
      mod_q    <= mod_d;
    end
  end

  // Same-cycle CPU read: row 8 only answers when every row line is high.
  always_comb begin
    held_s = 8'h00;
    for (int r = 0; r < 8; r++) begin
      held_s = held_s | (matrix_q[r] & {8{~addr[8+r]}});
    end
    held_s = held_s | (matrix_q[8] & {8{addr[15:8] == 8'hFF}});
  end

  assign key_data = ~held_s;
  assign Fn       = fn_q;
  assign mod      = mod_q;

endmodule

// File: tb/tb_sam_keyboard.sv
// Directed bench for sam_keyboard: PS/2 frames are bit-banged and the matrix, Fn and mod are checked.
// Timeout is scaled to 1000 cycles via CLK_HZ=1 MHz so a 1.1 ms idle stays short.
module tb_sam_keyboard;

  logic        clk_sys = 1'b0;
  logic        reset = 1'b1;
  logic        ps2_kbd_clk = 1'b1;
  logic        ps2_kbd_data = 1'b1;
  logic [15:0] addr = 16'h0000;
  logic [7:0]  key_data;
  logic [11:1] fn_o;
  logic [2:0]  mod_o;

  int vectors = 0;
  int miscompares = 0;

  sam_keyboard #(
    .CLK_HZ    (1000000),
    .TIMEOUT_US(1000)
  ) dut (
    .clk_sys     (clk_sys),
    .reset       (reset),
    .ps2_kbd_clk (ps2_kbd_clk),
    .ps2_kbd_data(ps2_kbd_data),
    .addr        (addr),
    .key_data    (key_data),
    .Fn          (fn_o),
    .mod         (mod_o)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic kd(input string tag, input logic [15:0] a, input logic [7:0] exp);
    @(negedge clk_sys);
    addr = a;
    #1;
    chk(tag, {8'h00, key_data}, {8'h00, exp});
  endtask

  task automatic flags(input string tag, input logic [11:1] fn_exp, input logic [2:0] mod_exp);
    @(negedge clk_sys);
    chk({tag, "_fn"}, {5'd0, fn_o}, {5'd0, fn_exp});
    chk({tag, "_mod"}, {13'd0, mod_o}, {13'd0, mod_exp});
  endtask

  task automatic send_bit(input logic b);
    ps2_kbd_data = b;
    repeat (10) @(posedge clk_sys);
    #1 ps2_kbd_clk = 1'b0;
    repeat (20) @(posedge clk_sys);
    #1 ps2_kbd_clk = 1'b1;
    repeat (10) @(posedge clk_sys);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic bad_par);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit((~^b) ^ bad_par);
    send_bit(1'b1);
    repeat (8) @(posedge clk_sys);
  endtask

  task automatic send(input logic [7:0] b);
    send_frame(b, 1'b0);
  endtask

  initial begin
    repeat (4) @(posedge clk_sys);
    kd("rst_kd_0000", 16'h0000, 8'hFF);
    kd("rst_kd_ffff", 16'hFFFF, 8'hFF);
    flags("rst", 11'h000, 3'b000);
    @(negedge clk_sys);
    reset = 1'b0;
    repeat (5) @(posedge clk_sys);

    send(8'h1C);
    kd("make_a_fdfe", 16'hFDFE, 8'hFE);
    kd("make_a_fefe", 16'hFEFE, 8'hFF);
    send(8'hF0); send(8'h1C);
    kd("break_a_fdfe", 16'hFDFE, 8'hFF);

    send(8'h15); send(8'h29);
    kd("merge_00fe", 16'h00FE, 8'hFE);
    kd("merge_fbfe", 16'hFBFE, 8'hFE);
    kd("merge_7ffe", 16'h7FFE, 8'hFE);
    kd("merge_fffe", 16'hFFFE, 8'hFF);
    kd("merge_fdfe", 16'hFDFE, 8'hFF);
    send(8'hF0); send(8'h15); send(8'hF0); send(8'h29);
    kd("merge_rel", 16'h00FE, 8'hFF);

    send(8'h11); send(8'h78);
    flags("alt_f11", 11'h400, 3'b010);
    send(8'hE0); send(8'h11); send(8'hF0); send(8'h11);
    flags("lalt_rel", 11'h400, 3'b010);
    send(8'hE0); send(8'hF0); send(8'h11);
    flags("ralt_rel", 11'h400, 3'b000);
    send(8'hF0); send(8'h78);
    flags("f11_rel", 11'h000, 3'b000);

    send(8'hE0); send(8'h75);
    kd("up_fffe", 16'hFFFE, 8'hFD);
    kd("up_00fe", 16'h00FE, 8'hFF);
    send(8'hE0); send(8'hF0); send(8'h75);
    kd("up_rel", 16'hFFFE, 8'hFF);

    send_bit(1'b0); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
    repeat (1100) @(posedge clk_sys);
    send(8'h1C);
    kd("tmo_0000", 16'h0000, 8'hFE);
    kd("tmo_ff00", 16'hFF00, 8'hFF);
    send(8'hF0); send(8'h1C);

    send(8'h1C); send(8'h15); send(8'h12); send(8'h05); send(8'hE0); send(8'h75);
    kd("ovr_pre_0000", 16'h0000, 8'hFE);
    kd("ovr_pre_ff00", 16'hFF00, 8'hFD);
    flags("ovr_pre", 11'h001, 3'b001);
    send(8'hFF);
    kd("ovr_0000", 16'h0000, 8'hFF);
    kd("ovr_ff00", 16'hFF00, 8'hFF);
    flags("ovr", 11'h000, 3'b000);

    send(8'h1C); send(8'h05); send(8'h12); send(8'hF0);
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
    @(negedge clk_sys);
    reset = 1'b1;
    @(negedge clk_sys);
    reset = 1'b0;
    #1;
    chk("rstmid_kd", {8'h00, key_data}, 16'h00FF);
    chk("rstmid_fn", {5'd0, fn_o}, 16'h0000);
    chk("rstmid_mod", {13'd0, mod_o}, 16'h0000);
    repeat (5) @(posedge clk_sys);
    #1;
    send(8'h1C);
    kd("rstmid_after", 16'hFDFE, 8'hFE);
    send(8'h00);
    kd("ovr00", 16'h0000, 8'hFF);

`ifdef SAMKBD_PARITY_CHECK_EN
    send_frame(8'h1C, 1'b1);
    kd("par_bad", 16'hFDFE, 8'hFF);
    send(8'hF0);
    send_frame(8'h1C, 1'b1);
    send(8'h1C);
    kd("par_clr_brk", 16'hFDFE, 8'hFE);
`else
    send_frame(8'h1C, 1'b1);
    kd("par_ignored", 16'hFDFE, 8'hFE);
    send(8'hF0); send(8'h1C);
    kd("par_rel", 16'hFDFE, 8'hFF);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sam_keyboard.md
SAM_KEYBOARD -- requirements
Module: sam_keyboard

Interface
REQ-001 Parameter CLK_HZ, default 96000000, clk_sys frequency used to size the PS/2 frame timeout.
REQ-002 Parameter TIMEOUT_US, default 1000, idle time in microseconds after which a partial PS/2 frame is abandoned.
REQ-003 clk_sys  in  1  system clock; one clock; all state SHALL be updated on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 ps2_kbd_clk  in  1  PS/2 keyboard clock; asynchronous to clk_sys.
REQ-006 ps2_kbd_data  in  1  PS/2 keyboard data; asynchronous to clk_sys.
REQ-007 addr  in  16  CPU address bus; addr[15:8] carries the row-select lines.
REQ-008 key_data  out  8  active-low column read for the selected rows.
  - [4:0] feed keyboard port 254.
  - [7:5] feed status port 249.
REQ-009 Fn  out  11 ([11:1])  active-high level flag per held function key F1..F11.
REQ-010 mod  out  3  active-high held modifiers: [0] shift, [1] alt, [2] ctrl.

Function
REQ-011 Synchroniser and edge detect:
  - ps2_kbd_clk and ps2_kbd_data SHALL pass through 2-flop synchronisers.
  - A bit SHALL be sampled on each detected falling edge of the synchronised clock.
REQ-012 Frame receiver: 11-bit frame, state machine with states IDLE, DATA, PARITY, STOP.
  - IDLE -> DATA on start bit = 0; a start bit of 1 is ignored.
  - DATA shifts 8 bits, LSB first.
  - PARITY captures the parity bit.
  - STOP: stop bit = 1 delivers the byte; stop bit = 0 discards it. Either way the state returns to IDLE.
REQ-013 Timeout: if no falling edge arrives for CLK_HZ/1000000*TIMEOUT_US cycles while not in IDLE, the receiver SHALL return to IDLE and discard the partial byte.
REQ-014 Decoder flags:
  - Byte E0 sets an ext flag; byte F0 sets a brk flag.
  - Any other byte is a key code, applied with the current flags; both flags then clear.
REQ-015 Make and break: a key code without brk sets the mapped key; with brk it clears the key. Codes with no mapping change no state.
REQ-016 Matrix and flags: a 9x8 key matrix plus Fn and mod flags SHALL update exactly 1 cycle after the STOP-state sample of the final byte.
REQ-017 Row select:
  - Row r (0..7) is selected when addr[8+r]=0.
  - Row 8 is selected only when addr[15:8]=FF.
  - key_data[c] SHALL be 0 if any selected row has key c held, else 1.
REQ-018 key_data SHALL be combinational from addr and the matrix, so a CPU read sees it in the same cycle.
REQ-019 Multiple selected rows SHALL be ANDed (active-low). addr[15:8]=00 selects rows 0..7 and not row 8.
REQ-020 Fn and mod:
  - Fn[n] tracks PS/2 F1..F11 held state.
  - mod tracks left/right shift, alt and ctrl; either side sets the bit, and a bit clears only when both sides are released.
REQ-021 Keyboard overrun bytes 00 or FF SHALL release every key, Fn and mod bit, and clear both flags.
REQ-022 Simultaneous events: a falling edge on the same cycle the timeout expires SHALL be treated as a timeout; that edge is not sampled.

Reset
REQ-023 While reset is high:
  - receiver SHALL be in IDLE with bit count 0 and timeout counter 0;
  - ext and brk SHALL be 0;
  - every matrix bit SHALL be released, giving key_data=FF for any addr;
  - Fn=0 and mod=0.
REQ-024 Reset asserted mid-frame SHALL discard the partial byte. The first edge after release is treated as a start-bit candidate.

Configuration
REQ-025 Macro SAMKBD_PARITY_CHECK_EN:
  - Defined: a byte whose 9 bits (data plus parity) have even parity SHALL be discarded, and ext/brk SHALL clear.
  - Undefined: the parity bit is sampled and ignored.

Structure
REQ-026 Package sam_kbd_pkg SHALL hold:
  - the receiver state enum;
  - prefix constants E0, F0, 00, FF;
  - the scan-code to {row, column} mapping function, with ext as input.
REQ-027 Sub-module ps2_rx SHALL contain REQ-011..013 and output a byte with a one-cycle valid strobe.
REQ-028 The decoder and matrix SHALL remain in sam_keyboard.

Verification
REQ-029 Make and read:
  - Stimulus: frame 1C ('A'), then addr=FDFE.
  - Required: key_data[4:0]=11110, key_data[7:5]=111, and addr=FEFE gives FF.
REQ-030 Break:
  - Stimulus: F0 1C after REQ-029.
  - Required: key_data=FF for addr=FDFE.
REQ-031 Row merge:
  - Stimulus: 15 ('Q', row 2 col 0) and 29 (space, row 7 col 0) held; addr=00FE.
  - Required: key_data[0]=0; addr=FBFE gives [0]=0; addr=7FFE gives [0]=0; addr=FFFE gives [4:0]=11111.
REQ-032 Modifiers and Fn:
  - Stimulus: 11 (alt), 78 (F11), then E0 11 (right alt) and F0 11.
  - Required: mod=010, Fn[11]=1.
  - After F0 11, mod[1] stays 1; after E0 F0 11, mod[1]=0.
REQ-033 Timeout and reset:
  - Stimulus: 5 bits of a frame, then idle 1.1 ms, then a full 1C frame.
  - Required: only 1C is decoded.
  - Reset pulse mid-frame: key_data=FF, Fn=0, mod=0 the cycle after.
REQ-034 Parity and overrun:
  - With SAMKBD_PARITY_CHECK_EN, 1C sent with a wrong parity bit leaves key_data=FF.
  - With several keys held, byte FF releases all of them.
